// File: rtl/point_spawner.sv
// point_spawner: NUM_POINTS collectible slots on a grid, player pickup detection, delayed pseudo-random respawn.
// Latency: overlap sampled on current player inputs; collect/expire pulses and point outputs are registered (1 cycle).
// Backpressure: none; game_en=0 freezes slots, clear empties all slots. Optional expiry under POINT_LIFETIME_EN.
module point_spawner #(
  parameter int NUM_POINTS    = 4,
  parameter int GRID_COLS     = 31,
  parameter int GRID_ROWS     = 23,
  parameter int CELL          = 32,
  parameter int POINT_SIZE    = 8,
  parameter int PLAYER_SIZE   = 16,
  parameter int RESPAWN_DELAY = 64,
  parameter int LIFETIME      = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    game_en,
  input  logic                    clear,
  input  logic [9:0]              player_x,
  input  logic [9:0]              player_y,
  output logic [10*NUM_POINTS-1:0] point_x,
  output logic [10*NUM_POINTS-1:0] point_y,
  output logic [NUM_POINTS-1:0]   point_active,
  output logic [NUM_POINTS-1:0]   collect_mask,
  output logic [3:0]              collect_cnt,
  output logic [NUM_POINTS-1:0]   expire_mask
);

  localparam int CB = $clog2(GRID_COLS);
  localparam int RB = $clog2(GRID_ROWS);
  localparam int DW = $clog2(RESPAWN_DELAY + 1);
  localparam logic [DW-1:0]        DLY_INIT = DW'(RESPAWN_DELAY);
  localparam logic signed [10:0]   HIT_DIST = 11'(POINT_SIZE + PLAYER_SIZE);

  // Elaboration guard: slot count must fit collect_cnt, delay must be at least one cycle.
  if (NUM_POINTS < 1 || NUM_POINTS > 8 || RESPAWN_DELAY < 1 || LIFETIME < 2) begin : g_param_check
    $error("point_spawner: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_SEARCH = 2'd1,
    S_ACTIVE = 2'd2
  } slot_state_t;

  logic [15:0]           lfsr;
  logic [15:0]           lfsr_nxt;
  logic [CB-1:0]         cand_col;
  logic [RB-1:0]         cand_row;
  logic [9:0]            cand_x;
  logic [9:0]            cand_y;
  logic                  cand_in_range;
  logic                  cand_hits_player;
  logic                  cand_taken;
  logic                  cand_ok;

  slot_state_t           state_q   [NUM_POINTS];
  slot_state_t           state_nxt [NUM_POINTS];
  logic [DW-1:0]         delay_q   [NUM_POINTS];
  logic [DW-1:0]         delay_nxt [NUM_POINTS];

  logic [NUM_POINTS-1:0] search_grant;
  logic [NUM_POINTS-1:0] slot_hit;
  logic [NUM_POINTS-1:0] spawn;
  logic [NUM_POINTS-1:0] collect_nxt;
  logic [NUM_POINTS-1:0] active_nxt;
  logic [NUM_POINTS-1:0] age_done;

  // Box overlap on 11-bit signed deltas so points near screen edges never wrap.
  function automatic logic overlap(input logic [9:0] ax, input logic [9:0] ay,
                                   input logic [9:0] bx, input logic [9:0] by);
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    dx = $signed({1'b0, ax}) - $signed({1'b0, bx});
    dy = $signed({1'b0, ay}) - $signed({1'b0, by});
    if (dx[10]) dx = -dx;
    if (dy[10]) dy = -dy;
    return (dx < HIT_DIST) && (dy < HIT_DIST);
  endfunction

  function automatic logic [3:0] popcount(input logic [NUM_POINTS-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < NUM_POINTS; i++) cnt = cnt + 4'(v[i]);
    return cnt;
  endfunction

  // Galois LFSR step, taps x^16+x^14+x^13+x^11+1; the all-zero state is unreachable from the seed.
  always_comb begin
    lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // LFSR free-runs regardless of game_en so the spawn pattern keeps moving while paused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= lfsr_nxt;
  end

  // Candidate cell from the LFSR and its acceptance test against range, player and occupied cells.
  always_comb begin
    cand_col         = lfsr[CB-1:0];
    cand_row         = lfsr[CB+RB-1:CB];
    cand_in_range    = (int'(cand_col) < GRID_COLS) && (int'(cand_row) < GRID_ROWS);
    cand_x           = 10'((int'(cand_col) + 1) * CELL);
    cand_y           = 10'((int'(cand_row) + 1) * CELL);
    cand_hits_player = overlap(cand_x, cand_y, player_x, player_y);
    cand_taken       = 1'b0;
    for (int i = 0; i < NUM_POINTS; i++) begin
      if (state_q[i] == S_ACTIVE &&
          point_x[10*i +: 10] == cand_x && point_y[10*i +: 10] == cand_y)
        cand_taken = 1'b1;
    end
    cand_ok = cand_in_range && !cand_hits_player && !cand_taken;
  end

  // Only the lowest-index searching slot may consume this cycle's candidate.
  always_comb begin
    logic found;
    found        = 1'b0;
    search_grant = '0;
    for (int i = 0; i < NUM_POINTS; i++) begin
      if (state_q[i] == S_SEARCH && !found) begin
        search_grant[i] = 1'b1;
        found           = 1'b1;
      end
    end
  end

  // Per-slot pickup detection against the current player position.
  always_comb begin
    slot_hit = '0;
    for (int i = 0; i < NUM_POINTS; i++) begin
      slot_hit[i] = (state_q[i] == S_ACTIVE) &&
                    overlap(point_x[10*i +: 10], point_y[10*i +: 10], player_x, player_y);
    end
  end

`ifdef POINT_LIFETIME_EN
  localparam int AW = $clog2(LIFETIME);

  logic [AW-1:0]         age_q [NUM_POINTS];
  logic [NUM_POINTS-1:0] expire_nxt;

  // Age has run out once it sits at LIFETIME-1 in an enabled ACTIVE cycle.
  always_comb begin
    age_done = '0;
    for (int i = 0; i < NUM_POINTS; i++) age_done[i] = (age_q[i] == AW'(LIFETIME - 1));
  end
`else
  // Without expiry points live until collected.
  always_comb begin
    age_done = '0;
  end

  assign expire_mask = '0;
`endif

  // Slot next-state: clear beats everything, game_en=0 freezes, collection beats expiry.
  always_comb begin
    spawn       = '0;
    collect_nxt = '0;
    active_nxt  = '0;
`ifdef POINT_LIFETIME_EN
    expire_nxt  = '0;
`endif
    for (int i = 0; i < NUM_POINTS; i++) begin
      state_nxt[i] = state_q[i];
      delay_nxt[i] = delay_q[i];
      if (clear) begin
        state_nxt[i] = S_EMPTY;
        delay_nxt[i] = DLY_INIT;
      end else if (game_en) begin
        case (state_q[i])
          S_EMPTY: begin
            // Leaving on the decrement that reaches zero gives exactly RESPAWN_DELAY empty cycles.
            if (delay_q[i] <= DW'(1)) begin
              state_nxt[i] = S_SEARCH;
              delay_nxt[i] = '0;
            end else begin
              delay_nxt[i] = delay_q[i] - DW'(1);
            end
          end
          S_SEARCH: begin
            if (search_grant[i] && cand_ok) begin
              state_nxt[i] = S_ACTIVE;
              spawn[i]     = 1'b1;
            end
          end
          S_ACTIVE: begin
            if (slot_hit[i]) begin
              state_nxt[i]   = S_EMPTY;
              delay_nxt[i]   = DLY_INIT;
              collect_nxt[i] = 1'b1;
            end else if (age_done[i]) begin
              state_nxt[i]   = S_EMPTY;
              delay_nxt[i]   = DLY_INIT;
`ifdef POINT_LIFETIME_EN
              expire_nxt[i]  = 1'b1;
`endif
            end
          end
          default: begin
            state_nxt[i] = S_EMPTY;
            delay_nxt[i] = DLY_INIT;
          end
        endcase
      end
      active_nxt[i] = (state_nxt[i] == S_ACTIVE);
    end
  end

  // Slot state plus registered outputs; positions survive collection and clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_POINTS; i++) begin
        state_q[i] <= S_EMPTY;
        delay_q[i] <= DLY_INIT;
      end
      point_x      <= '0;
      point_y      <= '0;
      point_active <= '0;
      collect_mask <= '0;
      collect_cnt  <= '0;
    end else begin
      for (int i = 0; i < NUM_POINTS; i++) begin
        state_q[i] <= state_nxt[i];
        delay_q[i] <= delay_nxt[i];
        if (spawn[i]) begin
          point_x[10*i +: 10] <= cand_x;
          point_y[10*i +: 10] <= cand_y;
        end
      end
      point_active <= active_nxt;
      collect_mask <= collect_nxt;
      collect_cnt  <= popcount(collect_nxt);
    end
  end

`ifdef POINT_LIFETIME_EN
  // Age counts enabled ACTIVE cycles and restarts whenever a slot (re)spawns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_POINTS; i++) age_q[i] <= '0;
      expire_mask <= '0;
    end else begin
      for (int i = 0; i < NUM_POINTS; i++) begin
        if (spawn[i] || state_q[i] != S_ACTIVE || clear) age_q[i] <= '0;
        else if (game_en)                                age_q[i] <= age_q[i] + AW'(1);
      end
      expire_mask <= expire_nxt;
    end
  end
`endif

endmodule
